// File: rtl/mcp_tx_pkg.sv
// mcp_tx_pkg: shared types, packet field layout and the configuration
// packet builder used by the master control path tx sequencer.
package mcp_tx_pkg;

    // Packet declare codes (bits [1:0] of every packet)
    localparam logic [1:0] PKT_DATA   = 2'b00;
    localparam logic [1:0] PKT_TEST   = 2'b01;
    localparam logic [1:0] PKT_CFG_WR = 2'b10;
    localparam logic [1:0] PKT_CFG_RD = 2'b11;

    // Packet field offsets
    localparam int unsigned PKT_W    = 64;
    localparam int unsigned DECL_LSB = 0;
    localparam int unsigned CHIP_LSB = 2;
    localparam int unsigned ADDR_LSB = 10;
    localparam int unsigned DATA_LSB = 18;
    localparam int unsigned PAR_BIT  = 63;

    // One queued register-access command; op: 0 = write, 1 = read
    typedef struct packed {
        logic       op;
        logic [7:0] chip_id;
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_t;

    // Format a command into a 64-bit config packet with odd parity in bit 63
    function automatic logic [PKT_W-1:0] build_cfg_pkt(input cmd_t cmd);
        logic [PKT_W-1:0] pkt;
        pkt = '0;
        pkt[DECL_LSB +: 2] = cmd.op ? PKT_CFG_RD : PKT_CFG_WR;
        pkt[CHIP_LSB +: 8] = cmd.chip_id;
        pkt[ADDR_LSB +: 8] = cmd.addr;
        pkt[DATA_LSB +: 8] = cmd.op ? 8'h00 : cmd.data;
        pkt[PAR_BIT]       = ~^pkt[PAR_BIT-1:0];
        return pkt;
    endfunction

endpackage

// File: rtl/mcp_tx_sequencer_fifo.sv
// mcp_cmd_fifo: synchronous command FIFO of cmd_t. Pointers carry one
// extra wrap bit so full/empty and the occupancy fall out of a subtraction.
module mcp_cmd_fifo
    import mcp_tx_pkg::*;
#(
    parameter int unsigned CMD_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  cmd_t                           wr_cmd,
    input  logic                           pop,
    output cmd_t                           rd_cmd,
    output logic [$clog2(CMD_DEPTH+1)-1:0] count,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned AW = $clog2(CMD_DEPTH);
    localparam int unsigned CW = $clog2(CMD_DEPTH+1);

    if ((CMD_DEPTH < 2) || (CMD_DEPTH > 64) || ((CMD_DEPTH & (CMD_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("mcp_cmd_fifo: CMD_DEPTH must be a power of two in 2..64");
    end

    cmd_t        mem [CMD_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = CW'(wr_ptr - rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_cmd  = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset flushes the queue and wins over a same-cycle push
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push && !reset) mem[wr_ptr[AW-1:0]] <= wr_cmd;
    end

endmodule

// File: rtl/mcp_tx_sequencer.sv
// mcp_tx_sequencer: queues LArPix register-access commands, formats each
// into a 64-bit config packet and hands them to uart_tx one at a time via
// the ld_tx_data / tx_busy handshake.
// Optional feature macro: MCP_TX_GAP_EN (adds GAP_CYCLES idle cycles after
// every completed packet).
module mcp_tx_sequencer
    import mcp_tx_pkg::*;
#(
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned CMD_DEPTH    = 8,
    parameter int unsigned BUSY_TIMEOUT = 16,
    parameter int unsigned GAP_CYCLES   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_op,
    input  logic [7:0]                     cmd_chip_id,
    input  logic [7:0]                     cmd_addr,
    input  logic [7:0]                     cmd_data,
    output logic [WIDTH-1:0]               tx_data,
    output logic                           ld_tx_data,
    input  logic                           tx_busy,
    output logic                           busy,
    output logic [$clog2(CMD_DEPTH+1)-1:0] fifo_count,
    output logic [15:0]                    sent_count,
    output logic                           timeout_err,
    input  logic                           clear_err
);

    if ((WIDTH != PKT_W) || (BUSY_TIMEOUT == 0) || (GAP_CYCLES == 0)) begin : g_bad_cfg
        $error("mcp_tx_sequencer: WIDTH must be 64, BUSY_TIMEOUT and GAP_CYCLES nonzero");
    end

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_DONE = 2'd2
`ifdef MCP_TX_GAP_EN
        , ST_GAP     = 2'd3
`endif
    } state_t;

    localparam int unsigned    TW        = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0]  LOAD_LAST = TW'(BUSY_TIMEOUT - 1);
`ifdef MCP_TX_GAP_EN
    localparam int unsigned    GW        = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0]  GAP_LAST  = GW'(GAP_CYCLES - 1);
    logic [GW-1:0]             gap_cnt;
`endif

    state_t        state;
    logic [TW-1:0] load_cnt;
    cmd_t          in_cmd;
    cmd_t          head_cmd;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;

    assign in_cmd    = '{op: cmd_op, chip_id: cmd_chip_id, addr: cmd_addr, data: cmd_data};
    assign pop       = (state == ST_IDLE) && !fifo_empty;
    assign cmd_ready = !fifo_full;
    assign busy      = !fifo_empty || (state != ST_IDLE);

    mcp_cmd_fifo #(
        .CMD_DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (cmd_valid),
        .wr_cmd (in_cmd),
        .pop    (pop),
        .rd_cmd (head_cmd),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Packet sequencing FSM with registered handshake outputs and status
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            tx_data     <= '0;
            ld_tx_data  <= 1'b0;
            load_cnt    <= '0;
            sent_count  <= '0;
            timeout_err <= 1'b0;
`ifdef MCP_TX_GAP_EN
            gap_cnt     <= '0;
`endif
        end else begin
            // Clear first so a timeout later in this block takes priority
            if (clear_err) timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        tx_data    <= build_cfg_pkt(head_cmd);
                        ld_tx_data <= 1'b1;
                        load_cnt   <= '0;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (tx_busy) begin
                        ld_tx_data <= 1'b0;
                        state      <= ST_WAIT_DONE;
                    end else if (load_cnt == LOAD_LAST) begin
                        ld_tx_data  <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        load_cnt <= load_cnt + TW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        sent_count <= sent_count + 16'd1;
`ifdef MCP_TX_GAP_EN
                        gap_cnt    <= '0;
                        state      <= ST_GAP;
`else
                        state      <= ST_IDLE;
`endif
                    end
                end
`ifdef MCP_TX_GAP_EN
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcp_tx_sequencer.sv
// tb_mcp_tx_sequencer: directed bench for mcp_tx_sequencer with a
// behavioural uart_tx busy responder.
module tb_mcp_tx_sequencer;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [7:0]  cmd_chip_id;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic [63:0] tx_data;
    logic        ld_tx_data;
    logic        tx_busy;
    logic        busy;
    logic [3:0]  fifo_count;
    logic [15:0] sent_count;
    logic        timeout_err;
    logic        clear_err;

    int vectors    = 0;
    int miscompares = 0;

    // Responder control and logs
    logic        resp_en;
    int          busy_len;
    int          cyc;
    int          bcnt;
    logic        ld_prev;
    int          rise_log[$];
    int          fall_log[$];
    logic [63:0] pkt_log[$];

    mcp_tx_sequencer #(
        .WIDTH        (64),
        .CMD_DEPTH    (8),
        .BUSY_TIMEOUT (16),
        .GAP_CYCLES   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_chip_id (cmd_chip_id),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .tx_data     (tx_data),
        .ld_tx_data  (ld_tx_data),
        .tx_busy     (tx_busy),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .sent_count  (sent_count),
        .timeout_err (timeout_err),
        .clear_err   (clear_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Independent packet model: fields by concatenation, parity by popcount
    function automatic logic [63:0] exp_pkt(input logic op, input logic [7:0] chip,
                                            input logic [7:0] addr, input logic [7:0] data);
        logic [62:0] body;
        body = {37'd0, (op ? 8'h00 : data), addr, chip, 1'b1, op};
        return {(($countones(body) % 2) == 0), body};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic push(input logic op, input logic [7:0] chip, input logic [7:0] addr,
                        input logic [7:0] data);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n == 200) check("push_ready_wait", {63'd0, cmd_ready}, 64'd1);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_chip_id = chip;
        cmd_addr    = addr;
        cmd_data    = data;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Behavioural uart_tx: raises busy for busy_len cycles after each load
    initial begin
        tx_busy = 1'b0;
        cyc     = 0;
        bcnt    = 0;
        ld_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (ld_tx_data && !ld_prev) begin
                rise_log.push_back(cyc);
                pkt_log.push_back(tx_data);
            end
            ld_prev = ld_tx_data;
            if (bcnt != 0) begin
                bcnt--;
                if (bcnt == 0) begin
                    tx_busy = 1'b0;
                    fall_log.push_back(cyc);
                end
            end else if (resp_en && ld_tx_data && !tx_busy) begin
                tx_busy = 1'b1;
                bcnt    = busy_len;
            end
        end
    end

    initial begin
        int n;
        int ldc;
        int gap;
        int exp_gap;
        logic [63:0] got;

        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 1'b0;
        cmd_chip_id = '0;
        cmd_addr    = '0;
        cmd_data    = '0;
        clear_err   = 1'b0;
        resp_en     = 1'b0;
        busy_len    = 5;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset values
        check("rst_tx_data", tx_data, 64'd0);
        check("rst_ld", {63'd0, ld_tx_data}, 64'd0);
        check("rst_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_count", {60'd0, fifo_count}, 64'd0);
        check("rst_sent", {48'd0, sent_count}, 64'd0);
        check("rst_err", {63'd0, timeout_err}, 64'd0);

        // Single write with latency check
        resp_en = 1'b1;
        busy_len = 5;
        rise_log.delete(); fall_log.delete(); pkt_log.delete();
        push(1'b0, 8'd16, 8'd1, 8'hA5);
        check("wr_ld_n1", {63'd0, ld_tx_data}, 64'd0);
        check("wr_count_n1", {60'd0, fifo_count}, 64'd1);
        @(negedge clk);
        check("wr_ld_n2", {63'd0, ld_tx_data}, 64'd1);
        check("wr_tx_n2", tx_data, 64'h0000_0000_0294_0442);
        n = 0;
        while (sent_count != 16'd1 && n < 200) begin @(negedge clk); n++; end
        check("wr_sent", {48'd0, sent_count}, 64'd1);
        check("wr_tx_hold", tx_data, 64'h0000_0000_0294_0442);
        check("wr_strobes", 64'(rise_log.size()), 64'd1);

        // Read with data field forced to zero
        rise_log.delete(); fall_log.delete(); pkt_log.delete();
        push(1'b1, 8'd255, 8'd0, 8'h7F);
        n = 0;
        while (sent_count != 16'd2 && n < 200) begin @(negedge clk); n++; end
        check("rd_sent", {48'd0, sent_count}, 64'd2);
        check("rd_tx", tx_data, 64'h8000_0000_0000_03FF);
        check("rd_strobes", 64'(rise_log.size()), 64'd1);

        // Fill: 9 back-to-back pushes with the uart stalled
        resp_en = 1'b0;
        n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        rise_log.delete(); fall_log.delete(); pkt_log.delete();
        for (int i = 0; i < 9; i++)
            push(i[0], 8'(i * 3 + 1), 8'(i + 32), 8'(17 * i));
        check("fill_count", {60'd0, fifo_count}, 64'd8);
        check("fill_ready_low", {63'd0, cmd_ready}, 64'd0);
        resp_en = 1'b1;
        n = 0;
        while (fifo_count != 4'd7 && n < 200) begin @(negedge clk); n++; end
        check("fill_ready_back", {63'd0, cmd_ready}, 64'd1);
        n = 0;
        while (sent_count != 16'd11 && n < 800) begin @(negedge clk); n++; end
        check("fill_sent", {48'd0, sent_count}, 64'd11);
        check("fill_strobes", 64'(pkt_log.size()), 64'd9);
        for (int i = 0; i < 9; i++) begin
            got = (i < pkt_log.size()) ? pkt_log[i] : 'x;
            check($sformatf("fill_pkt%0d", i), got,
                  exp_pkt(i[0], 8'(i * 3 + 1), 8'(i + 32), 8'(17 * i)));
        end
        check("fill_err_clear", {63'd0, timeout_err}, 64'd0);

        // Timeout with tx_busy tied low
        resp_en = 1'b0;
        n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        push(1'b0, 8'h05, 8'h10, 8'h3C);
        n = 0;
        ldc = 0;
        while (!timeout_err && n < 64) begin
            if (ld_tx_data) ldc++;
            @(negedge clk);
            n++;
        end
        check("to_ld_cycles", 64'(ldc), 64'd16);
        check("to_err", {63'd0, timeout_err}, 64'd1);
        check("to_ld_low", {63'd0, ld_tx_data}, 64'd0);
        check("to_sent", {48'd0, sent_count}, 64'd11);
        repeat (3) @(negedge clk);
        check("to_sticky", {63'd0, timeout_err}, 64'd1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("to_cleared", {63'd0, timeout_err}, 64'd0);

        // Timeout while clear_err is held: set wins
        clear_err = 1'b1;
        push(1'b1, 8'h07, 8'h02, 8'h00);
        n = 0;
        while (!timeout_err && n < 64) begin @(negedge clk); n++; end
        check("to2_set_wins", {63'd0, timeout_err}, 64'd1);
        @(negedge clk);
        check("to2_then_clear", {63'd0, timeout_err}, 64'd0);
        clear_err = 1'b0;

        // Inter-packet gap
        resp_en  = 1'b1;
        busy_len = 3;
        rise_log.delete(); fall_log.delete(); pkt_log.delete();
        push(1'b0, 8'h21, 8'h03, 8'h44);
        push(1'b0, 8'h22, 8'h04, 8'h55);
        n = 0;
        while (sent_count != 16'd13 && n < 300) begin @(negedge clk); n++; end
        check("gap_sent", {48'd0, sent_count}, 64'd13);
        gap = (rise_log.size() >= 2 && fall_log.size() >= 1) ? (rise_log[1] - fall_log[0] - 1) : -1;
`ifdef MCP_TX_GAP_EN
        exp_gap = 5;
`else
        exp_gap = 1;
`endif
        check("gap_cycles", 64'(gap), 64'(exp_gap));
        check("gap_tx_last", tx_data, exp_pkt(1'b0, 8'h22, 8'h04, 8'h55));

        // Reset during WAIT_DONE with 3 commands queued
        busy_len = 30;
        n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        for (int i = 0; i < 4; i++)
            push(1'b0, 8'(64 + i), 8'(i), 8'(i + 1));
        check("rstm_count", {60'd0, fifo_count}, 64'd3);
        check("rstm_in_wait", {63'd0, ld_tx_data}, 64'd0);
        reset       = 1'b1;
        cmd_valid   = 1'b1;
        cmd_chip_id = 8'h99;
        @(negedge clk);
        reset     = 1'b0;
        cmd_valid = 1'b0;
        check("rstm_count0", {60'd0, fifo_count}, 64'd0);
        check("rstm_ld", {63'd0, ld_tx_data}, 64'd0);
        check("rstm_tx", tx_data, 64'd0);
        check("rstm_busy", {63'd0, busy}, 64'd0);
        check("rstm_sent", {48'd0, sent_count}, 64'd0);
        ldc = 0;
        repeat (40) begin
            @(negedge clk);
            if (ld_tx_data) ldc++;
        end
        check("rstm_no_load", 64'(ldc), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mcp_tx_sequencer.md
# mcp_tx_sequencer

Synthesizable command sequencer that sits directly upstream of `uart_tx` in the master control path. It accepts LArPix register-access commands on a valid/ready interface and buffers them in a small FIFO. It formats each command into a 64-bit configuration packet with odd parity, then drives `uart_tx` one packet at a time through the `ld_tx_data`/`tx_busy` handshake. The block is clocked by the same clock as `uart_tx` (the tx clock).

## Interface
Parameters:
- `WIDTH`, 64, packet width; fixed at 64.
- `CMD_DEPTH`, 8, command FIFO depth; power of two, 2..64.
- `BUSY_TIMEOUT`, 16, maximum cycles in LOAD waiting for `tx_busy`.
- `GAP_CYCLES`, 4, idle cycles inserted after each packet; only used with `MCP_TX_GAP_EN`.

Ports:
- `clk` in 1: tx clock, shared with `uart_tx`.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept a command.
- `cmd_op` in 1: 0 = config write, 1 = config read.
- `cmd_chip_id` in 8: target chip; 255 = global broadcast.
- `cmd_addr` in 8: register map address.
- `cmd_data` in 8: write data; ignored for reads.
- `tx_data` out 64: packet presented to `uart_tx`.
- `ld_tx_data` out 1: load strobe to `uart_tx`.
- `tx_busy` in 1: `uart_tx` is shifting.
- `busy` out 1: FIFO non-empty or FSM not IDLE.
- `fifo_count` out `$clog2(CMD_DEPTH+1)`: commands queued.
- `sent_count` out 16: packets completed; wraps 0xFFFF→0.
- `timeout_err` out 1: sticky; `tx_busy` never asserted.
- `clear_err` in 1: clears `timeout_err`.

## Operation
- Packet fields:
  - [1:0] declare: 2'b10 for write, 2'b11 for read.
  - [9:2] `chip_id`.
  - [17:10] `addr`.
  - [25:18] `data`, forced to 0 for reads.
  - [62:26] 0.
  - [63] odd parity: `~^pkt[62:0]`, so the total number of ones across all 64 bits is odd.
- Accept: a push happens when `cmd_valid && cmd_ready`. `cmd_ready = !full`, combinational from the count.
- Simultaneous push and pop are legal when the FIFO is neither full nor empty; `fifo_count` is unchanged.
- FSM states:
  - IDLE: when the FIFO is non-empty, pop, register the formatted packet into `tx_data`, and go to LOAD.
  - LOAD: `ld_tx_data=1`. If `tx_busy` is sampled high, go to WAIT_DONE. If the cycle counter reaches `BUSY_TIMEOUT`, set `timeout_err`, drop the packet and go to IDLE.
  - WAIT_DONE: `ld_tx_data=0`. When `tx_busy` is sampled low, increment `sent_count` and go to GAP (macro defined) or IDLE.
  - GAP: count `GAP_CYCLES`, then go to IDLE.
- `tx_data` holds the last packet after completion.
- If `clear_err` and a new timeout occur in the same cycle, set wins.
- Reset mid-packet returns to IDLE and flushes the FIFO. Any command presented in the reset cycle is discarded.

## Timing
- Reset values:
  - `tx_data`=0, `ld_tx_data`=0, `cmd_ready`=1, `busy`=0.
  - `fifo_count`=0, `sent_count`=0, `timeout_err`=0.
  - State = IDLE.
- Latency: a command pushed at cycle N into an empty FIFO, with the FSM in IDLE, is popped at N+1. `tx_data` and `ld_tx_data=1` are visible from N+2.
- `ld_tx_data` stays high from LOAD entry through the cycle `tx_busy` is first sampled high. It drops the next cycle.
- Back-to-back packets: minimum of 1 IDLE cycle between WAIT_DONE exit and the next LOAD, plus `GAP_CYCLES` when the gap feature is enabled.
- A timeout fires after exactly `BUSY_TIMEOUT` LOAD cycles. `timeout_err` is visible the following cycle.

## Configuration
- Macro: `MCP_TX_GAP_EN`.
- Defined: the GAP state is present and inserts `GAP_CYCLES` idle cycles after every completed packet. This keeps the chip's rx line idle between configuration words.
- Undefined: the GAP state and its counter are absent, and WAIT_DONE goes directly to IDLE.

## Structure
- Package `mcp_tx_pkg` holds:
  - Declare constants `PKT_DATA=2'b00`, `PKT_TEST=2'b01`, `PKT_CFG_WR=2'b10`, `PKT_CFG_RD=2'b11`.
  - Field offset localparams.
  - A `cmd_t` packed struct {op, chip_id, addr, data}.
  - Function `build_cfg_pkt(cmd_t)` returning 64 bits with parity.
- Sub-module `mcp_cmd_fifo`: synchronous FIFO of `cmd_t` with depth `CMD_DEPTH`. It provides count, full and empty, and uses wrap-around pointers with one extra bit.

## Test plan
- Write chip 16, addr 1, data 0xA5 with `tx_busy` from a real `uart_tx` → `tx_data` = 64'h0000_0000_0294_0442, exactly one load strobe, `sent_count`=1.
- Read chip 255, addr 0, data 0x7F → `tx_data` = 64'h8000_0000_0000_03FF (data field zeroed).
- Push 9 commands back-to-back with `CMD_DEPTH`=8 and `tx_busy` held low → `cmd_ready` low after the 8th accepted command in the queue. After the first pop it recovers. No command is lost, and the transmit order matches the push order.
- Tie `tx_busy`=0 → `timeout_err` rises after 16 LOAD cycles. The packet is dropped and `sent_count` is unchanged. `clear_err` then clears the flag.
- Assert `reset` during WAIT_DONE with 3 commands queued → next cycle state IDLE, `fifo_count`=0, `ld_tx_data`=0, `tx_data`=0.
- With `MCP_TX_GAP_EN` and `GAP_CYCLES`=4, send two commands → 5 cycles from `tx_busy` falling to the second `ld_tx_data` rising. Without the macro, 1 cycle.
